// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: hazard inputs from the pipeline and control back.
// Perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             branch_taken;
    logic             pc_load;
    logic             if_id_load;
    logic             id_ex_load;
    logic             ex_mem_load;
    logic             mem_wb_load;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             mem_ex_rdata_hazard;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      lu_count;
`endif

    modport master (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  imem_resp, dmem_req, dmem_resp, branch_taken,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        output id_ex_bubble, if_id_flush, fwd_a_sel, fwd_b_sel,
`ifdef HAZARD_PERF_EN
        output stall_cycles, lu_count,
`endif
        output mem_ex_rdata_hazard
    );

    modport slave (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output imem_resp, dmem_req, dmem_resp, branch_taken,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
        input  id_ex_bubble, if_id_flush, fwd_a_sel, fwd_b_sel,
`ifdef HAZARD_PERF_EN
        input  stall_cycles, lu_count,
`endif
        input  mem_ex_rdata_hazard
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the five-stage pipeline.
// Define HAZARD_PERF_EN to add the stall_cycles/lu_count counters.
module hazard_ctrl #(
    parameter int REG_W = 5
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.master hz
);
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic [1:0] {RUN, DWAIT, IWAIT} state_t;

    state_t state, state_nxt;
    logic   pending_flush, pending_nxt;
    logic   dstall, istall, freeze;
    logic   flush, load_use, lu_bubble;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] mrd,
        input logic             mrw,
        input logic [REG_W-1:0] wrd,
        input logic             wrw
    );
        if (mrw && mrd != X0 && mrd == rs) return 2'b01;
        if (wrw && wrd != X0 && wrd == rs) return 2'b10;
        return 2'b00;
    endfunction

    assign dstall = hz.dmem_req & ~hz.dmem_resp;
    assign istall = ~hz.imem_resp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            pending_flush <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending_flush <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        unique case (state)
            RUN: begin
                freeze = dstall | istall;
                if (dstall)      state_nxt = DWAIT;
                else if (istall) state_nxt = IWAIT;
            end
            DWAIT: begin
                freeze = ~hz.dmem_resp;
                if (hz.dmem_resp) state_nxt = istall ? IWAIT : RUN;
            end
            IWAIT: begin
                freeze = ~hz.imem_resp;
                if (hz.imem_resp) state_nxt = dstall ? DWAIT : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A redirect seen while frozen is replayed on the release cycle
    assign pending_nxt = freeze & (pending_flush | hz.branch_taken);
    assign flush       = ~freeze & (pending_flush | hz.branch_taken);
    assign load_use    = ~freeze & hz.ex_memread & (hz.ex_rd != X0) &
                         ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));
    assign lu_bubble   = load_use & ~flush;

    always_comb begin
        hz.pc_load             = 1'b0;
        hz.if_id_load          = 1'b0;
        hz.id_ex_load          = 1'b0;
        hz.ex_mem_load         = 1'b0;
        hz.mem_wb_load         = 1'b0;
        hz.id_ex_bubble        = 1'b0;
        hz.if_id_flush         = 1'b0;
        hz.mem_ex_rdata_hazard = 1'b0;
        hz.fwd_a_sel           = 2'b00;
        hz.fwd_b_sel           = 2'b00;
        if (!reset) begin
            hz.pc_load             = ~freeze & ~lu_bubble;
            hz.if_id_load          = ~freeze & ~lu_bubble;
            hz.id_ex_load          = ~freeze;
            hz.ex_mem_load         = ~freeze;
            hz.mem_wb_load         = ~freeze;
            hz.id_ex_bubble        = flush | lu_bubble;
            hz.if_id_flush         = flush;
            hz.mem_ex_rdata_hazard = freeze;
            hz.fwd_a_sel = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite,
                                   hz.wb_rd, hz.wb_regwrite);
            hz.fwd_b_sel = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite,
                                   hz.wb_rd, hz.wb_regwrite);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, lu_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            lu_q    <= '0;
        end else begin
            if (freeze)    stall_q <= stall_q + 32'd1;
            if (lu_bubble) lu_q    <= lu_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.lu_count     = lu_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(5)) hz();
    hazard_ctrl #(.REG_W(5)) dut (.clk(clk), .reset(reset), .hz(hz));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
        logic       ex_memread;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
        logic       imem_resp, dmem_req, dmem_resp, branch_taken;
    } in_t;

    // ld = {pc, if_id, id_ex, ex_mem, mem_wb}
    typedef struct packed {
        logic [4:0] ld;
        logic       bub, fl, haz;
        logic [1:0] fa, fb;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  e;
        string n;
    } vec_t;

    // reference model: what the pipeline is waiting on (0 none, 1 D, 2 I)
    int          m_wait;
    bit          m_pend;
    int unsigned m_stall, m_lu;

    function automatic out_t mko(logic [4:0] ld, logic bub, logic fl,
                                 logic haz, logic [1:0] fa, logic [1:0] fb);
        out_t o;
        o.ld = ld; o.bub = bub; o.fl = fl; o.haz = haz; o.fa = fa; o.fb = fb;
        return o;
    endfunction

    function automatic bit m_frozen(in_t v);
        if (m_wait == 1) return !v.dmem_resp;
        if (m_wait == 2) return !v.imem_resp;
        return (v.dmem_req && !v.dmem_resp) || !v.imem_resp;
    endfunction

    function automatic logic [1:0] m_fwd(logic [4:0] rs, in_t v);
        if (rs == 0) return 2'd0;
        if (v.mem_regwrite && v.mem_rd == rs) return 2'd1;
        if (v.wb_regwrite && v.wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_lu_hit(in_t v);
        return v.ex_memread && v.ex_rd != 0 &&
               (v.ex_rd == v.id_rs1 || v.ex_rd == v.id_rs2);
    endfunction

    function automatic out_t model_out(in_t v, bit rst);
        out_t o = '0;
        bit   redir;
        if (rst) return o;
        o.fa = m_fwd(v.ex_rs1, v);
        o.fb = m_fwd(v.ex_rs2, v);
        if (m_frozen(v)) begin
            o.haz = 1'b1;
            return o;
        end
        redir = v.branch_taken || m_pend;
        o.ld  = 5'b11111;
        if (redir) begin
            o.bub = 1'b1;
            o.fl  = 1'b1;
        end else if (m_lu_hit(v)) begin
            o.ld  = 5'b00111;
            o.bub = 1'b1;
        end
        return o;
    endfunction

    function automatic void model_step(in_t v, bit rst);
        bit frz;
        if (rst) begin
            m_wait = 0; m_pend = 0; m_stall = 0; m_lu = 0;
            return;
        end
        frz = m_frozen(v);
        if (frz) m_stall++;
        if (!frz && !(v.branch_taken || m_pend) && m_lu_hit(v)) m_lu++;
        m_pend = frz && (m_pend || v.branch_taken);
        // keep waiting until served, else pick up a new stall (D first)
        if (m_wait == 1 && !v.dmem_resp)      m_wait = 1;
        else if (m_wait == 2 && !v.imem_resp) m_wait = 2;
        else if (v.dmem_req && !v.dmem_resp)  m_wait = 1;
        else if (!v.imem_resp)                m_wait = 2;
        else                                  m_wait = 0;
    endfunction

    task automatic apply(in_t v);
        hz.id_rs1 = v.id_rs1; hz.id_rs2 = v.id_rs2;
        hz.ex_rs1 = v.ex_rs1; hz.ex_rs2 = v.ex_rs2;
        hz.ex_rd = v.ex_rd; hz.ex_memread = v.ex_memread;
        hz.mem_rd = v.mem_rd; hz.mem_regwrite = v.mem_regwrite;
        hz.wb_rd = v.wb_rd; hz.wb_regwrite = v.wb_regwrite;
        hz.imem_resp = v.imem_resp; hz.dmem_req = v.dmem_req;
        hz.dmem_resp = v.dmem_resp; hz.branch_taken = v.branch_taken;
    endtask

    function automatic out_t actual();
        out_t o;
        o.ld  = {hz.pc_load, hz.if_id_load, hz.id_ex_load,
                 hz.ex_mem_load, hz.mem_wb_load};
        o.bub = hz.id_ex_bubble;
        o.fl  = hz.if_id_flush;
        o.haz = hz.mem_ex_rdata_hazard;
        o.fa  = hz.fwd_a_sel;
        o.fb  = hz.fwd_b_sel;
        return o;
    endfunction

    task automatic check32(string n, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end
    endtask

    // one clock: drive, sample mid-cycle, compare, advance
    task automatic cyc(in_t v, bit rst, out_t e, string n);
        out_t a;
        reset = rst;
        apply(v);
        #4;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got ld=%b bub=%b fl=%b haz=%b fa=%b fb=%b want ld=%b bub=%b fl=%b haz=%b fa=%b fb=%b",
                     n, a.ld, a.bub, a.fl, a.haz, a.fa, a.fb,
                     e.ld, e.bub, e.fl, e.haz, e.fa, e.fb);
        end
`ifdef HAZARD_PERF_EN
        check32({n, ".stall_cycles"}, hz.stall_cycles, m_stall);
        check32({n, ".lu_count"}, hz.lu_count, m_lu);
`endif
        model_step(v, rst);
        @(posedge clk);
        #1;
    endtask

    in_t  idle, v;
    out_t ALL, FRZ, LU, FLS, ZERO;
    vec_t vt[11];

    initial begin
        idle = '0;
        idle.imem_resp = 1'b1;
        ALL  = mko(5'b11111, 0, 0, 0, 2'd0, 2'd0);
        FRZ  = mko(5'b00000, 0, 0, 1, 2'd0, 2'd0);
        LU   = mko(5'b00111, 1, 0, 0, 2'd0, 2'd0);
        FLS  = mko(5'b11111, 1, 1, 0, 2'd0, 2'd0);
        ZERO = '0;
        m_wait = 0; m_pend = 0; m_stall = 0; m_lu = 0;

        for (int k = 0; k < 11; k++) begin
            vt[k].i = idle;
            vt[k].e = ALL;
        end
        vt[0].n = "lu_rs2";
        vt[0].i.ex_memread = 1; vt[0].i.ex_rd = 5; vt[0].i.id_rs2 = 5;
        vt[0].e = LU;
        vt[1].n = "lu_rs1";
        vt[1].i.ex_memread = 1; vt[1].i.ex_rd = 3; vt[1].i.id_rs1 = 3;
        vt[1].e = LU;
        vt[2].n = "lu_x0";
        vt[2].i.ex_memread = 1;
        vt[3].n = "no_load";
        vt[3].i.ex_rd = 5; vt[3].i.id_rs1 = 5;
        vt[4].n = "br_over_lu";
        vt[4].i.ex_memread = 1; vt[4].i.ex_rd = 6; vt[4].i.id_rs1 = 6;
        vt[4].i.branch_taken = 1;
        vt[4].e = FLS;
        vt[5].n = "fwd_mem_prio";
        vt[5].i.ex_rs1 = 7; vt[5].i.mem_rd = 7; vt[5].i.wb_rd = 7;
        vt[5].i.mem_regwrite = 1; vt[5].i.wb_regwrite = 1;
        vt[5].e = mko(5'b11111, 0, 0, 0, 2'd1, 2'd0);
        vt[6].n = "fwd_wb";
        vt[6].i = vt[5].i; vt[6].i.mem_regwrite = 0;
        vt[6].e = mko(5'b11111, 0, 0, 0, 2'd2, 2'd0);
        vt[7].n = "fwd_x0";
        vt[7].i.mem_regwrite = 1; vt[7].i.wb_regwrite = 1;
        vt[8].n = "fwd_ab_wb";
        vt[8].i.ex_rs1 = 9; vt[8].i.ex_rs2 = 9; vt[8].i.mem_rd = 9;
        vt[8].i.wb_rd = 9; vt[8].i.wb_regwrite = 1;
        vt[8].e = mko(5'b11111, 0, 0, 0, 2'd2, 2'd2);
        vt[9].n = "dmem_hit";
        vt[9].i.dmem_req = 1; vt[9].i.dmem_resp = 1;
        vt[10].n = "fwd_split";
        vt[10].i.ex_rs1 = 2; vt[10].i.ex_rs2 = 9;
        vt[10].i.mem_rd = 9; vt[10].i.mem_regwrite = 1;
        vt[10].i.wb_rd = 2; vt[10].i.wb_regwrite = 1;
        vt[10].e = mko(5'b11111, 0, 0, 0, 2'd2, 2'd1);

        reset = 1'b1;
        apply(idle);
        @(posedge clk);
        #1;

        // reset forces everything low even with busy inputs
        v = vt[4].i; v.dmem_req = 1; v.ex_rs1 = 3; v.mem_rd = 3;
        v.mem_regwrite = 1;
        cyc(v, 1, ZERO, "reset_outs");
        cyc(idle, 0, ALL, "post_reset_idle");

        for (int k = 0; k < 11; k++) cyc(vt[k].i, 0, vt[k].e, vt[k].n);

        // load-use: exactly one bubble, counted once
        cyc(idle, 1, ZERO, "rst");
        cyc(vt[0].i, 0, LU, "lu_seq");
        cyc(idle, 0, ALL, "lu_next");
`ifdef HAZARD_PERF_EN
        check32("lu_count_one", hz.lu_count, 32'd1);
`endif

        // D-cache miss, three freeze cycles
        cyc(idle, 1, ZERO, "rst");
        v = idle; v.dmem_req = 1;
        for (int k = 0; k < 3; k++) cyc(v, 0, FRZ, "dmiss_frz");
        v.dmem_resp = 1;
        reset = 0; apply(v); #4;
`ifdef HAZARD_PERF_EN
        check32("dmiss_stall_cycles", hz.stall_cycles, 32'd3);
`endif
        #0;
        @(negedge clk);
        #0;
        @(posedge clk); #1;
        model_step(v, 0);
        cyc(v, 0, ALL, "dmiss_after");

        // branch during a D stall is deferred to the release cycle
        v = idle; v.dmem_req = 1; v.branch_taken = 1;
        cyc(v, 0, FRZ, "br_frz1");
        v.branch_taken = 0;
        cyc(v, 0, FRZ, "br_frz2");
        v.dmem_resp = 1;
        cyc(v, 0, FLS, "br_release");
        cyc(idle, 0, ALL, "br_after");

        // combined stall: DWAIT, then IWAIT after dmem_resp
        v = idle; v.dmem_req = 1; v.imem_resp = 0;
        cyc(v, 0, FRZ, "comb_frz1");
        cyc(v, 0, FRZ, "comb_frz2");
        v.dmem_resp = 1;
        cyc(v, 0, ALL, "comb_d_release");
        v.dmem_resp = 0;
        cyc(v, 0, FRZ, "comb_iwait");
        v.imem_resp = 1;
        cyc(v, 0, ALL, "comb_i_release");
        cyc(v, 0, FRZ, "comb_dwait");
        v.dmem_resp = 1;
        cyc(v, 0, ALL, "comb_d_release2");

        // reset mid-DWAIT drops the pending flush
        v = idle; v.dmem_req = 1; v.branch_taken = 1;
        cyc(v, 0, FRZ, "rst_mid_frz1");
        v.branch_taken = 0;
        cyc(v, 0, FRZ, "rst_mid_frz2");
        cyc(v, 1, ZERO, "rst_mid");
        cyc(idle, 0, ALL, "rst_mid_after");
`ifdef HAZARD_PERF_EN
        check32("rst_mid_stall_zero", hz.stall_cycles, 32'd0);
        check32("rst_mid_lu_zero", hz.lu_count, 32'd0);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit r;
            v.id_rs1 = 5'($urandom_range(0, 3));
            v.id_rs2 = 5'($urandom_range(0, 3));
            v.ex_rs1 = 5'($urandom_range(0, 3));
            v.ex_rs2 = 5'($urandom_range(0, 3));
            v.ex_rd = 5'($urandom_range(0, 3));
            v.mem_rd = 5'($urandom_range(0, 3));
            v.wb_rd = 5'($urandom_range(0, 3));
            v.ex_memread = 1'($urandom_range(0, 1));
            v.mem_regwrite = 1'($urandom_range(0, 1));
            v.wb_regwrite = 1'($urandom_range(0, 1));
            v.imem_resp = ($urandom_range(0, 3) != 0);
            v.dmem_req = ($urandom_range(0, 2) == 0);
            v.dmem_resp = 1'($urandom_range(0, 1));
            v.branch_taken = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 49) == 0);
            cyc(v, r, model_out(v, r), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
